// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with per-press debounce and a small
// first-word-fall-through key FIFO feeding the CPU keypad register.
// Ports: clk, rst_n (async active-low); rows[3:0] in (active low,
// async); cols[3:0] out (one-hot low); rd_en pops the head; clr_ovf
// clears overflow; key_data/key_valid/key_count show the FIFO head and
// fill level; overflow is a sticky dropped-press flag; scan_state is a
// debug view (0=SCAN, 1=DEBOUNCE, 2=RELEASE).
// Optional macro KEYPAD_REPEAT_EN: auto-repeat while a key stays held.
module keypad_scanner #(
    parameter int SCAN_DIV        = 5000,
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int FIFO_DEPTH      = 4,
    parameter int REPEAT_CYCLES   = 25000000
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [3:0]                        rows,
    output logic [3:0]                        cols,
    input  logic                              rd_en,
    input  logic                              clr_ovf,
    output logic [3:0]                        key_data,
    output logic                              key_valid,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   key_count,
    output logic                              overflow,
    output logic [1:0]                        scan_state
);

    localparam int DW  = $clog2(SCAN_DIV);
    localparam int DBW = $clog2(DEBOUNCE_CYCLES);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        RELEASE  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [3:0]     rows_m, rows_s;
    logic [DW-1:0]  div_cnt;
    logic [DBW-1:0] deb_cnt;
    logic [1:0]     col_idx;
    logic [1:0]     row_idx;
    logic [1:0]     row_enc;
    logic [3:0]     p_q;
    logic           div_tc, deb_tc, rows_idle, rows_match;
    logic           deb_push, rep_push, push;
    logic           col_adv, latch_p;

    // rows is asynchronous to clk
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rows_m <= 4'hF;
            rows_s <= 4'hF;
        end else begin
            rows_m <= rows;
            rows_s <= rows_m;
        end
    end

    assign div_tc     = (div_cnt == DW'(SCAN_DIV - 1));
    assign deb_tc     = (deb_cnt == DBW'(DEBOUNCE_CYCLES - 1));
    assign rows_idle  = (rows_s == 4'hF);
    assign rows_match = (rows_s == p_q);

    // Lowest-indexed low row wins when several rows are pressed
    always_comb begin
        row_enc = 2'd3;
        if (!rows_s[0])      row_enc = 2'd0;
        else if (!rows_s[1]) row_enc = 2'd1;
        else if (!rows_s[2]) row_enc = 2'd2;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= SCAN;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            SCAN: begin
                if (div_tc && !rows_idle) state_d = DEBOUNCE;
            end
            DEBOUNCE: begin
                if (!rows_match)  state_d = SCAN;
                else if (deb_tc)  state_d = RELEASE;
            end
            RELEASE: begin
                if (rows_idle && deb_tc) state_d = SCAN;
            end
            default: state_d = SCAN;
        endcase
    end

    always_comb begin
        deb_push = (state_q == DEBOUNCE) && rows_match && deb_tc;
        latch_p  = (state_q == SCAN) && div_tc && !rows_idle;
        col_adv  = ((state_q == SCAN) && div_tc && rows_idle) ||
                   ((state_q == RELEASE) && rows_idle && deb_tc);
        push     = deb_push || rep_push;
    end

    assign scan_state = state_q;
    assign cols       = ~(4'b0001 << col_idx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            deb_cnt <= '0;
            col_idx <= 2'd0;
            row_idx <= 2'd0;
            p_q     <= 4'hF;
        end else begin
            if (state_q != SCAN || div_tc) div_cnt <= '0;
            else                           div_cnt <= div_cnt + 1'b1;

            unique case (state_q)
                DEBOUNCE: begin
                    if (!rows_match || deb_tc) deb_cnt <= '0;
                    else                       deb_cnt <= deb_cnt + 1'b1;
                end
                RELEASE: begin
                    if (!rows_idle || deb_tc) deb_cnt <= '0;
                    else                      deb_cnt <= deb_cnt + 1'b1;
                end
                default: deb_cnt <= '0;
            endcase

            if (col_adv) col_idx <= col_idx + 2'd1;
            if (latch_p) begin
                p_q     <= rows_s;
                row_idx <= row_enc;
            end
        end
    end

`ifdef KEYPAD_REPEAT_EN
    localparam int RPW = $clog2(REPEAT_CYCLES);
    logic [RPW-1:0] rep_cnt;
    logic           rep_hold, rep_tc;

    assign rep_hold = (state_q == RELEASE) && rows_match;
    assign rep_tc   = (rep_cnt == RPW'(REPEAT_CYCLES - 1));
    assign rep_push = rep_hold && rep_tc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 rep_cnt <= '0;
        else if (!rep_hold || rep_tc) rep_cnt <= '0;
        else                        rep_cnt <= rep_cnt + 1'b1;
    end
`else
    // Repeat disabled: REPEAT_CYCLES has no effect
    assign rep_push = 1'b0 & (REPEAT_CYCLES != 0);
`endif

    logic [3:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count_q;
    logic          full, do_pop, do_push, ovf_evt;

    assign full    = (count_q == CW'(FIFO_DEPTH));
    assign do_pop  = rd_en && (count_q != '0);
    // A full FIFO still accepts a push when the head leaves this cycle
    assign do_push = push && (!full || do_pop);
    assign ovf_evt = push && full && !do_pop;

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= {row_idx, col_idx};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_q  <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
            if (ovf_evt)      overflow <= 1'b1;
            else if (clr_ovf) overflow <= 1'b0;
        end
    end

    assign key_count = count_q;
    assign key_valid = (count_q != '0);
    assign key_data  = key_valid ? mem[rd_ptr] : 4'h0;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a behavioural keypad drives rows from the
// pressed-key set and the DUT's column drive.
module tb_keypad_scanner;

    localparam int SD = 4;
    localparam int DC = 8;
    localparam int FD = 4;
    localparam int RC = 32;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] rows;
    logic [3:0] cols;
    logic       rd_en = 1'b0;
    logic       clr_ovf = 1'b0;
    logic [3:0] key_data;
    logic       key_valid;
    logic [2:0] key_count;
    logic       overflow;
    logic [1:0] scan_state;
    logic [15:0] keys = 16'h0;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // key index = row*4 + col, which is also its code
    always_comb begin
        rows = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !cols[c]) rows[r] = 1'b0;
    end

    keypad_scanner #(
        .SCAN_DIV(SD),
        .DEBOUNCE_CYCLES(DC),
        .FIFO_DEPTH(FD),
        .REPEAT_CYCLES(RC)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .rows(rows),
        .cols(cols),
        .rd_en(rd_en),
        .clr_ovf(clr_ovf),
        .key_data(key_data),
        .key_valid(key_valid),
        .key_count(key_count),
        .overflow(overflow),
        .scan_state(scan_state)
    );

    typedef struct {
        logic [15:0] keys;
        logic [3:0]  code;
    } vec_t;

    vec_t vecs[5];

    logic [3:0] mq[$];
    bit         mov;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [15:0] k, input int hold,
                         input int rel);
        keys = k;
        cyc(hold);
        keys = 16'h0;
        cyc(rel);
    endtask

    task automatic pop();
        rd_en = 1'b1;
        cyc(1);
        rd_en = 1'b0;
    endtask

    task automatic wait_state(input logic [1:0] s, input int budget,
                              input string name);
        int n = 0;
        while (scan_state !== s && n < budget) begin
            cyc(1);
            n++;
        end
        chk(name, scan_state, s);
    endtask

    task automatic model_push(input logic [3:0] code);
        if (mq.size() < FD) mq.push_back(code);
        else                mov = 1'b1;
    endtask

    task automatic check_model(input string tag);
        logic [3:0] hd;
        hd = (mq.size() != 0) ? mq[0] : 4'h0;
        chk({tag, "_count"}, key_count, mq.size());
        chk({tag, "_valid"}, key_valid, mq.size() != 0);
        chk({tag, "_data"}, key_data, hd);
        chk({tag, "_ovf"}, overflow, mov);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] ec;
        int         op;
        logic [3:0] rk;

        vecs[0] = '{16'h0200, 4'h9};
        vecs[1] = '{16'h0001, 4'h0};
        vecs[2] = '{16'h8000, 4'hF};
        vecs[3] = '{16'h4040, 4'h6};
        vecs[4] = '{16'h0888, 4'h3};

        cyc(2);
        chk("rst_cols", cols, 4'b1110);
        chk("rst_state", scan_state, 2'd0);
        chk("rst_valid", key_valid, 1'b0);
        chk("rst_count", key_count, 3'd0);
        chk("rst_data", key_data, 4'h0);
        chk("rst_ovf", overflow, 1'b0);

        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            ec = ~(4'b0001 << ((k / SD) % 4));
            chk("idle_cols", cols, ec);
            chk("idle_state", scan_state, 2'd0);
            chk("idle_valid", key_valid, 1'b0);
            cyc(1);
        end

        for (int i = 0; i < 5; i++) begin
            press(vecs[i].keys, 36, 20);
            chk("vec_valid", key_valid, 1'b1);
            chk("vec_data", key_data, vecs[i].code);
            chk("vec_count", key_count, 3'd1);
            chk("vec_state", scan_state, 2'd0);
            pop();
            chk("vec_pop_valid", key_valid, 1'b0);
            chk("vec_pop_count", key_count, 3'd0);
        end

        pop();
        chk("empty_pop_count", key_count, 3'd0);

        for (int i = 0; i < 10; i++) begin
            keys = (i % 2 == 0) ? 16'h0200 : 16'h0000;
            cyc(3);
        end
        chk("bounce_count", key_count, 3'd0);
        press(16'h0200, 36, 20);
        chk("bounce_after_count", key_count, 3'd1);
        chk("bounce_after_data", key_data, 4'h9);
        pop();

        for (int i = 1; i <= 5; i++) press(16'h1 << i, 36, 20);
        chk("ovf_count", key_count, 3'd4);
        chk("ovf_flag", overflow, 1'b1);
        chk("ovf_head", key_data, 4'h1);
        clr_ovf = 1'b1;
        cyc(1);
        clr_ovf = 1'b0;
        chk("ovf_clr", overflow, 1'b0);

        keys = 16'h0040;
        wait_state(2'd1, 40, "sim_deb_enter");
        cyc(DC - 1);
        rd_en = 1'b1;
        cyc(1);
        rd_en = 1'b0;
        chk("sim_state", scan_state, 2'd2);
        chk("sim_count", key_count, 3'd4);
        chk("sim_ovf", overflow, 1'b0);
        keys = 16'h0;
        cyc(20);
        for (int i = 0; i < 4; i++) begin
            ec = (i == 3) ? 4'h6 : 4'(i + 2);
            chk("sim_read", key_data, ec);
            pop();
        end
        chk("sim_empty", key_valid, 1'b0);

        rst_n = 1'b0;
        keys = 16'h1004;
        cyc(2);
        rst_n = 1'b1;
        cyc(36);
        keys = 16'h0;
        cyc(20);
        chk("multicol_count", key_count, 3'd1);
        chk("multicol_data", key_data, 4'hC);
        pop();

        keys = 16'h0020;
        wait_state(2'd2, 60, "rep_rel_enter");
        cyc(100);
        keys = 16'h0;
        cyc(20);
`ifdef KEYPAD_REPEAT_EN
        chk("rep_count", key_count, 3'd4);
`else
        chk("rep_count", key_count, 3'd1);
`endif
        chk("rep_ovf", overflow, 1'b0);
        while (key_valid === 1'b1) begin
            chk("rep_data", key_data, 4'h5);
            pop();
        end

        keys = 16'h0020;
        wait_state(2'd2, 60, "rst_hold_rel");
        chk("rst_hold_count", key_count, 3'd1);
        rst_n = 1'b0;
        cyc(1);
        chk("rst_hold_empty", key_count, 3'd0);
        chk("rst_hold_valid", key_valid, 1'b0);
        chk("rst_hold_cols", cols, 4'b1110);
        chk("rst_hold_state", scan_state, 2'd0);
        rst_n = 1'b1;
        cyc(36);
        keys = 16'h0;
        cyc(20);
        chk("redetect_count", key_count, 3'd1);
        chk("redetect_data", key_data, 4'h5);
        pop();

        mq.delete();
        mov = 1'b0;
        check_model("rnd_start");
        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 9);
            rk = 4'($urandom_range(0, 15));
            if (op <= 4) begin
                press(16'h1 << rk, 36, 20);
                model_push(rk);
            end else if (op <= 6) begin
                press(16'h1 << rk, $urandom_range(1, 5), 20);
            end else if (op <= 8) begin
                pop();
                if (mq.size() != 0) void'(mq.pop_front());
            end else begin
                clr_ovf = 1'b1;
                cyc(1);
                clr_ovf = 1'b0;
                mov = 1'b0;
            end
            check_model("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
